intersection_scheduler: RTL



---
 rtl/intersection_scheduler_pkg.sv | 28 ++
 rtl/intersection_scheduler_phase_timer.sv | 36 +++
 rtl/intersection_scheduler.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/intersection_scheduler_pkg.sv
// Shared phase codes, road identifiers and reset-time duration defaults
// for the two-road intersection scheduler.
package traffic_pkg;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_G     = 8;
  localparam int DEF_Y     = 2;
  localparam int DEF_R     = 1;
  localparam int DEF_P     = 5;

  // Encoding is visible on the debug phase port, so it is fixed explicitly.
  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    AR_NS = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    AR_EW = 3'd5,
    PED   = 3'd6,
    ILL   = 3'd7
  } phase_e;

  typedef enum logic {
    ROAD_NS = 1'b0,
    ROAD_EW = 1'b1
  } road_e;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Per-phase cycle counter: counts 1..dur, flags the last cycle, and can be
// frozen or forced back to 1.
module phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic             restart_i,
  input  logic [CNT_W-1:0] dur_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] dur_eff;

  // A zero-length phase would never reach done, so it runs for one cycle.
  assign dur_eff = (dur_i == '0) ? CNT_W'(1) : dur_i;
  assign done_o  = (cnt_q == dur_eff);

  always_comb begin
    if (restart_i)   cnt_d = CNT_W'(1);
    else if (hold_i) cnt_d = cnt_q;
    else if (done_o) cnt_d = CNT_W'(1);
    else             cnt_d = cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= CNT_W'(1);
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/intersection_scheduler.sv
// Two-road intersection sequencer with all-red clearance, pedestrian walk
// arbitration and run-time loadable phase durations.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int G_DEF = DEF_G,
  parameter int Y_DEF = DEF_Y,
  parameter int R_DEF = DEF_R,
  parameter int P_DEF = DEF_P
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Set,
  input  logic             Stop,
  input  logic             Jump,
  input  logic             ped_req,
  input  logic [CNT_W-1:0] Gin,
  input  logic [CNT_W-1:0] Yin,
  input  logic [CNT_W-1:0] Rin,
  input  logic [CNT_W-1:0] Pin,
  output logic             ns_g,
  output logic             ns_y,
  output logic             ns_r,
  output logic             ew_g,
  output logic             ew_y,
  output logic             ew_r,
  output logic             walk,
  output logic             ped_ack,
  output logic [2:0]       phase
);

  phase_e           state_q, state_d;
  road_e            next_road_q, next_road_d;
  logic             ped_pend_q, ped_pend_d;
  logic             ped_ack_q, ped_ack_d;
  logic [CNT_W-1:0] g_q, y_q, r_q, p_q;
  logic [CNT_W-1:0] dur;
  logic             done;
  logic             illegal;
  logic             jump_eff;
  logic             restart;

  assign illegal  = (state_q == ILL);
  assign jump_eff = Jump && (state_q inside {NS_G, NS_Y, EW_G, EW_Y});
  assign restart  = Set || illegal || (!Stop && jump_eff);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dur = r_q;
    unique case (state_q)
      NS_G, EW_G: dur = g_q;
      NS_Y, EW_Y: dur = y_q;
      PED:        dur = p_q;
      default:    dur = r_q;
    endcase
  end

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst_n     (reset),
    .hold_i    (Stop),
    .restart_i (restart),
    .dur_i     (dur),
    .done_o    (done)
  );

  always_comb begin
    state_d     = state_q;
    next_road_d = next_road_q;
    ped_pend_d  = ped_pend_q || (ped_req && state_q != PED);
    ped_ack_d   = 1'b0;
    if (Set) begin
      state_d     = NS_G;
      next_road_d = ROAD_EW;
      ped_pend_d  = 1'b0;
    end else if (illegal) begin
      state_d = NS_G;
    end else if (Stop) begin
      state_d = state_q;
    end else if (jump_eff) begin
      state_d = (state_q inside {NS_G, NS_Y}) ? AR_NS : AR_EW;
    end else if (done) begin
      unique case (state_q)
        NS_G: state_d = NS_Y;
        NS_Y: state_d = AR_NS;
        EW_G: state_d = EW_Y;
        EW_Y: state_d = AR_EW;
        AR_NS, AR_EW: begin
          // The walk phase is decided on the registered request only, so a
          // request arriving on the exit cycle waits for the next clearance.
          next_road_d = (state_q == AR_NS) ? ROAD_EW : ROAD_NS;
          if (ped_pend_q) begin
            state_d    = PED;
            ped_pend_d = 1'b0;
            ped_ack_d  = 1'b1;
          end else begin
            state_d = (state_q == AR_NS) ? EW_G : NS_G;
          end
        end
        PED:     state_d = (next_road_q == ROAD_EW) ? EW_G : NS_G;
        default: state_d = NS_G;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= NS_G;
      next_road_q <= ROAD_EW;
      ped_pend_q  <= 1'b0;
      ped_ack_q   <= 1'b0;
      g_q         <= CNT_W'(G_DEF);
      y_q         <= CNT_W'(Y_DEF);
      r_q         <= CNT_W'(R_DEF);
      p_q         <= CNT_W'(P_DEF);
    end else begin
      state_q     <= state_d;
      next_road_q <= next_road_d;
      ped_pend_q  <= ped_pend_d;
      ped_ack_q   <= ped_ack_d;
      if (Set) begin
        g_q <= Gin;
        y_q <= Yin;
        r_q <= Rin;
        p_q <= Pin;
      end
    end
  end

  always_comb begin
    ns_g = 1'b0;
    ns_y = 1'b0;
    ns_r = 1'b0;
    ew_g = 1'b0;
    ew_y = 1'b0;
    ew_r = 1'b0;
    walk = 1'b0;
    unique case (state_q)
      NS_G: begin ns_g = 1'b1; ew_r = 1'b1; end
      NS_Y: begin ns_y = 1'b1; ew_r = 1'b1; end
      EW_G: begin ew_g = 1'b1; ns_r = 1'b1; end
      EW_Y: begin ew_y = 1'b1; ns_r = 1'b1; end
      PED:  begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
      default: begin ns_r = 1'b1; ew_r = 1'b1; end
    endcase
  end

  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule
